// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Four requesters share a dual-port RAM through a round-robin
//            arbiter; the RAM is zero-filled after every reset.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                req,
  input  logic [3:0]                we,
  input  logic [4*ADDR_WIDTH-1:0]   addr,
  input  logic [4*DATA_WIDTH-1:0]   wdata,
  output logic [3:0]                gnt,
  output logic [3:0]                rvalid,
  output logic [4*DATA_WIDTH-1:0]   rdata,
  output logic                      busy,
  output logic                      ram_en_a,
  output logic                      ram_en_b,
  output logic                      ram_we_a,
  output logic                      ram_we_b,
  output logic [ADDR_WIDTH-1:0]     ram_addr_a,
  output logic [ADDR_WIDTH-1:0]     ram_addr_b,
  output logic [DATA_WIDTH-1:0]     ram_wdata_a,
  output logic [DATA_WIDTH-1:0]     ram_wdata_b,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_a,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_b
);

  localparam int NREQ  = 4;
  localparam int DEPTH = 2**ADDR_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Each init cycle clears one even/odd address pair, so the counter covers DEPTH/2 steps.
  localparam logic [ADDR_WIDTH-2:0] INIT_LAST = (ADDR_WIDTH-1)'(DEPTH/2 - 1);

  logic [0:0]            state_q,    state_d;
  logic [ADDR_WIDTH-2:0] init_cnt_q, init_cnt_d;
  logic [1:0]            ptr_q,      ptr_d;
  logic [3:0]            rvalid_q,   rvalid_d;
  logic [3:0]            tag_q,      tag_d;

  logic [ADDR_WIDTH-1:0] addr_s  [NREQ];
  logic [DATA_WIDTH-1:0] wdata_s [NREQ];

  logic       first_found, second_found;
  logic [1:0] first_idx, second_idx, cand;
  logic       run, conflict, win_a, win_b;

  generate
    for (genvar k = 0; k < NREQ; k++) begin : g_slot
      assign addr_s[k]  = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_s[k] = wdata[k*DATA_WIDTH +: DATA_WIDTH];
      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
        rvalid_q[k] ? (tag_q[k] ? ram_rdata_b : ram_rdata_a) : '0;
    end
  endgenerate

  assign busy   = (state_q == ST_INIT);
  assign rvalid = rvalid_q;
  assign run    = (state_q == ST_RUN) && !rst;

  // Round-robin scan starting at the pointer; first hit takes port A, second port B.
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = 2'd0;
    second_idx   = 2'd0;
    cand         = 2'd0;
    for (int j = 0; j < NREQ; j++) begin
      cand = ptr_q + 2'(j);
      if (req[cand]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = cand;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = cand;
        end
      end
    end
  end

  // Two accesses to one address are only safe when both are reads.
  assign conflict = first_found && second_found &&
                    (addr_s[first_idx] == addr_s[second_idx]) &&
                    (we[first_idx] || we[second_idx]);
  assign win_a    = run && first_found;
  assign win_b    = run && second_found && !conflict;

  always_comb begin
    gnt = 4'b0000;
    if (win_a) gnt[first_idx]  = 1'b1;
    if (win_b) gnt[second_idx] = 1'b1;
  end

  always_comb begin
    ram_en_a    = 1'b0;
    ram_we_a    = 1'b0;
    ram_addr_a  = '0;
    ram_wdata_a = '0;
    ram_en_b    = 1'b0;
    ram_we_b    = 1'b0;
    ram_addr_b  = '0;
    ram_wdata_b = '0;
    if (state_q == ST_INIT && !rst) begin
      ram_en_a   = 1'b1;
      ram_we_a   = 1'b1;
      ram_addr_a = {init_cnt_q, 1'b0};
      ram_en_b   = 1'b1;
      ram_we_b   = 1'b1;
      ram_addr_b = {init_cnt_q, 1'b1};
    end else begin
      if (win_a) begin
        ram_en_a    = 1'b1;
        ram_we_a    = we[first_idx];
        ram_addr_a  = addr_s[first_idx];
        ram_wdata_a = wdata_s[first_idx];
      end
      if (win_b) begin
        ram_en_b    = 1'b1;
        ram_we_b    = we[second_idx];
        ram_addr_b  = addr_s[second_idx];
        ram_wdata_b = wdata_s[second_idx];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ptr_d      = ptr_q;
    rvalid_d   = 4'b0000;
    tag_d      = 4'b0000;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == INIT_LAST) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end else begin
      if (win_b)      ptr_d = second_idx + 2'd1;
      else if (win_a) ptr_d = first_idx + 2'd1;
      if (win_a && !we[first_idx]) rvalid_d[first_idx] = 1'b1;
      // The tag remembers which RAM port will return this requester's data.
      if (win_b && !we[second_idx]) begin
        rvalid_d[second_idx] = 1'b1;
        tag_d[second_idx]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ptr_q      <= 2'd0;
      rvalid_q   <= 4'b0000;
      tag_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
      tag_q      <= tag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Directed self-checking bench for ram_port_arbiter with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt, rvalid;
  logic [4*DW-1:0] rdata;
  logic            busy;
  logic            ram_en_a, ram_en_b, ram_we_a, ram_we_b;
  logic [AW-1:0]   ram_addr_a, ram_addr_b;
  logic [DW-1:0]   ram_wdata_a, ram_wdata_b;
  logic [DW-1:0]   ram_rdata_a, ram_rdata_b;

  logic [DW-1:0]   mem [DEPTH];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .ram_en_a(ram_en_a), .ram_en_b(ram_en_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
  );

  // Dual-port RAM model, one-cycle read latency; filled with 0xFF while in reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else begin
      if (ram_en_a) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
        else          ram_rdata_a     <= mem[ram_addr_a];
      end
      if (ram_en_b) begin
        if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
        else          ram_rdata_b     <= mem[ram_addr_b];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k]              = r;
    we[k]               = w;
    addr[k*AW +: AW]    = a;
    wdata[k*DW +: DW]   = d;
  endtask

  initial begin
    int nonzero;
    logic [AW-1:0] ea, eb;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    ram_rdata_a = '0; ram_rdata_b = '0;
    tick(); tick();

    check_eq("rst_busy",   busy, 1'b1);
    check_eq("rst_gnt",    gnt, 4'b0000);
    check_eq("rst_en",     {ram_en_a, ram_en_b}, 2'b00);
    check_eq("rst_rvalid", rvalid, 4'b0000);

    // Zero-fill: 32 cycles of busy, even addresses on A and odd on B.
    rst = 1'b0;
    #1;
    for (int i = 0; i < DEPTH/2; i++) begin
      ea = AW'(2*i);
      eb = AW'(2*i + 1);
      check_eq("init_busy", busy, 1'b1);
      check_eq("init_gnt",  gnt, 4'b0000);
      check_eq("init_a", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}, {1'b1, 1'b1, ea, 8'h00});
      check_eq("init_b", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b}, {1'b1, 1'b1, eb, 8'h00});
      tick();
    end
    check_eq("run_busy", busy, 1'b0);
    check_eq("idle_a", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}, 16'h0000);
    check_eq("idle_b", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b}, 16'h0000);
    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 8'h00) nonzero++;
    check_eq("init_fill", 64'(nonzero), 64'd0);

    // Write/read conflict on address 5, pointer at 0.
    drive(1, 1'b1, 1'b1, 6'd5, 8'hA5);
    drive(2, 1'b1, 1'b0, 6'd5, 8'h00);
    #1;
    check_eq("conf_gnt", gnt, 4'b0010);
    check_eq("conf_a", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}, {1'b1, 1'b1, 6'd5, 8'hA5});
    check_eq("conf_b", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b}, 16'h0000);
    tick();
    drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
    #1;
    check_eq("conf_gnt2", gnt, 4'b0100);
    check_eq("conf_a2", {ram_en_a, ram_we_a, ram_addr_a}, {1'b1, 1'b0, 6'd5});
    check_eq("wr_no_rvalid", rvalid, 4'b0000);
    tick();
    req = '0;
    #1;
    check_eq("conf_rvalid", rvalid, 4'b0100);
    check_eq("conf_rdata", rdata, 32'h00A5_0000);
    check_eq("idle_gnt", gnt, 4'b0000);

    // Four writes to 16..19 starting from pointer 3.
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b1, AW'(16 + k), DW'(8'h10 + k));
    #1;
    check_eq("wr_gnt1", gnt, 4'b1001);
    check_eq("wr_a1", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}, {1'b1, 1'b1, 6'd19, 8'h13});
    check_eq("wr_b1", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b}, {1'b1, 1'b1, 6'd16, 8'h10});
    tick();
    check_eq("wr_gnt2", gnt, 4'b0110);
    check_eq("wr_a2", {ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a}, {1'b1, 1'b1, 6'd17, 8'h11});
    check_eq("wr_b2", {ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b}, {1'b1, 1'b1, 6'd18, 8'h12});
    check_eq("wr_rvalid", rvalid, 4'b0000);
    tick();

    // Lone requester 3 holding req: granted every cycle on port A.
    req = '0; we = '0;
    drive(3, 1'b1, 1'b0, 6'd19, 8'h00);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("solo_gnt", gnt, 4'b1000);
      check_eq("solo_a", {ram_en_a, ram_we_a, ram_addr_a}, {1'b1, 1'b0, 6'd19});
      check_eq("solo_b_idle", ram_en_b, 1'b0);
      if (c > 0) begin
        check_eq("solo_rvalid", rvalid, 4'b1000);
        check_eq("solo_rdata", rdata, 32'h1300_0000);
      end
      tick();
    end
    req = '0;
    #1;
    check_eq("solo_rvalid_last", rvalid, 4'b1000);
    check_eq("solo_rdata_last", rdata, 32'h1300_0000);

    // All four read distinct addresses from pointer 0.
    for (int k = 0; k < 4; k++) drive(k, 1'b1, 1'b0, AW'(16 + k), 8'h00);
    #1;
    check_eq("rr_gnt1", gnt, 4'b0011);
    check_eq("rr_a1", {ram_en_a, ram_we_a, ram_addr_a}, {1'b1, 1'b0, 6'd16});
    check_eq("rr_b1", {ram_en_b, ram_we_b, ram_addr_b}, {1'b1, 1'b0, 6'd17});
    tick();
    check_eq("rr_gnt2", gnt, 4'b1100);
    check_eq("rr_rvalid1", rvalid, 4'b0011);
    check_eq("rr_rdata1", rdata, 32'h0000_1110);
    tick();
    check_eq("rr_gnt3", gnt, 4'b0011);
    check_eq("rr_rvalid2", rvalid, 4'b1100);
    check_eq("rr_rdata2", rdata, 32'h1312_0000);
    tick();
    req = '0;
    #1;
    check_eq("rr_rvalid3", rvalid, 4'b0011);
    check_eq("rr_rdata3", rdata, 32'h0000_1110);

    // Requester 1 stores 0x5C at 9, then requesters 0 and 3 read 9 together.
    we = '0;
    drive(1, 1'b1, 1'b1, 6'd9, 8'h5C);
    #1;
    check_eq("w9_gnt", gnt, 4'b0010);
    tick();
    req = '0; we = '0;
    drive(0, 1'b1, 1'b0, 6'd9, 8'h00);
    drive(3, 1'b1, 1'b0, 6'd9, 8'h00);
    #1;
    check_eq("rr9_gnt", gnt, 4'b1001);
    check_eq("rr9_a", {ram_en_a, ram_we_a, ram_addr_a}, {1'b1, 1'b0, 6'd9});
    check_eq("rr9_b", {ram_en_b, ram_we_b, ram_addr_b}, {1'b1, 1'b0, 6'd9});
    tick();
    req = '0;
    #1;
    check_eq("rr9_rvalid", rvalid, 4'b1001);
    check_eq("rr9_rdata", rdata, 32'h5C00_005C);

    // Reset lands on the edge that would return a granted read.
    drive(1, 1'b1, 1'b0, 6'd9, 8'h00);
    #1;
    check_eq("pre_rst_gnt", gnt, 4'b0010);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rvalid", rvalid, 4'b0000);
    check_eq("mid_rst_busy", busy, 1'b1);
    check_eq("mid_rst_gnt", gnt, 4'b0000);
    check_eq("mid_rst_en", {ram_en_a, ram_en_b}, 2'b00);
    tick();
    check_eq("mid_rst_rvalid2", rvalid, 4'b0000);
    req = '0;
    rst = 1'b0;
    #1;
    check_eq("reinit_a0", {ram_en_a, ram_we_a, ram_addr_a}, {1'b1, 1'b1, 6'd0});
    check_eq("reinit_b0", {ram_en_b, ram_we_b, ram_addr_b}, {1'b1, 1'b1, 6'd1});
    check_eq("reinit_busy", busy, 1'b1);
    tick();
    check_eq("reinit_a1", ram_addr_a, 6'd2);
    check_eq("reinit_rvalid", rvalid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, word width; ADDR_WIDTH, default 6, address width; DEPTH is derived as 2**ADDR_WIDTH.
REQ-002 The requester count SHALL be fixed at 4, indexed 0..3; slot k of a packed bus occupies bits [(k+1)*W-1 : k*W].
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  4  per-requester access request.
REQ-006 we  in  4  per-requester write (1) / read (0) select.
REQ-007 addr  in  4*ADDR_WIDTH  per-requester address.
REQ-008 wdata  in  4*DATA_WIDTH  per-requester write data.
REQ-009 gnt  out  4  combinational grant; the access is taken at the clock edge where req[k] and gnt[k] are both 1.
REQ-010 rvalid  out  4  registered; read data for requester k is on rdata slot k.
REQ-011 rdata  out  4*DATA_WIDTH  per-requester read data; a slot is 0 when its rvalid bit is 0.
REQ-012 busy  out  1  high while RAM initialisation runs.
REQ-013 ram_en_a, ram_en_b  out  1 each  port A / B access enable.
REQ-014 ram_we_a, ram_we_b  out  1 each  port write (1) / read (0).
REQ-015 ram_addr_a, ram_addr_b  out  ADDR_WIDTH each  port address.
REQ-016 ram_wdata_a, ram_wdata_b  out  DATA_WIDTH each  port write data.
REQ-017 ram_rdata_a, ram_rdata_b  in  DATA_WIDTH each  port read data, valid one cycle after a read is issued.

Function
REQ-018 The FSM SHALL have two states, INIT and RUN; INIT moves to RUN after the last init cycle; RUN has no exit except reset.
REQ-019 In INIT, init counter i SHALL run 0..DEPTH/2-1, one step per cycle: port A writes 0 to address 2i, port B writes 0 to address 2i+1.
REQ-020 In INIT, busy = 1, gnt = 0 and rvalid = 0; INIT lasts exactly DEPTH/2 cycles (32 at defaults).
REQ-021 In RUN, busy = 0; each cycle, scan req starting at round-robin pointer p, modulo 4: the first requester found wins port A, the second wins port B.
REQ-022 Address conflict: if both winners use the same address and at least one of them writes, only the port A winner is granted; the second is not granted and stays pending.
REQ-023 Two reads to the same address SHALL both be granted.
REQ-024 Pointer update: p becomes (index of the last granted requester + 1) mod 4; with no grant, p is unchanged.
REQ-025 A port with no winner SHALL drive en = 0, we = 0, address 0 and wdata 0.
REQ-026 A granted read SHALL set rvalid[k] = 1 exactly one cycle later, for one cycle, with rdata slot k taken from the port it used; the port tag is registered alongside rvalid.
REQ-027 A granted write SHALL produce no rvalid.
REQ-028 A requester SHALL receive at most one port per cycle.
REQ-029 Any requester holding req = 1 SHALL be granted within 3 cycles (starvation bound).

Reset
REQ-030 rst = 1 SHALL immediately force: state INIT, i = 0, p = 0, rvalid = 0, rvalid tags 0, busy = 1.
REQ-031 While rst = 1, gnt = 0 and ram_en_a = ram_en_b = 0.
REQ-032 The first init write SHALL occur on the first rising edge after rst falls.
REQ-033 Reset asserted during RUN SHALL discard all pending read returns and restart INIT from i = 0.

Verification
REQ-034 Release reset, defaults -> busy high for exactly 32 cycles; addresses 0..63 written with 0, even addresses on port A and odd on port B; busy then falls.
REQ-035 RUN, p = 0, req = 4'b1111, all reads to distinct addresses -> gnt = 0011, then 1100, then 0011; rvalid follows each grant by one cycle.
REQ-036 Requester 1 writes 0xA5 to address 5 while requester 2 reads address 5, same cycle, p = 0 -> only gnt[1]; next cycle gnt[2]; rvalid[2] then returns 0xA5.
REQ-037 Requesters 0 and 3 read address 9 in the same cycle -> both granted, on ports A and B; both rvalid bits high one cycle later with equal data.
REQ-038 Reset asserted on the cycle after a read grant -> no rvalid pulse; busy = 1; INIT restarts at i = 0.
REQ-039 A single requester holds req = 1 continuously -> granted every cycle on port A; port B stays idle (en = 0).
